// File: rtl/pls_gen_pkg.sv
// Shared types for the per-axis pulse generator.
// Word and context layouts used by the pulse FIFO and its consumer.
package pls_gen_pkg;

    localparam int TS_WIDTH      = 16;
    localparam int N_WIDTH       = 16;
    localparam int V_WIDTH       = 16;
    localparam int ID_WIDTH      = 8;
    localparam int PLS_W         = 8;
    localparam int DIR_SETUP_DEF = 16;

    typedef struct packed {
        logic [TS_WIDTH-1:0] t;
        logic                mask;
        logic                is_v;
        logic [N_WIDTH-1:0]  n;
        logic                dir;
        logic [V_WIDTH-1:0]  v;
        logic [ID_WIDTH-1:0] id;
    } pls_data_t;

    typedef struct packed {
        logic [ID_WIDTH-1:0] id;
        logic [N_WIDTH-1:0]  n;
        logic [V_WIDTH-1:0]  v;
        logic                is_v;
    } pls_ctx_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DSET,
        ST_RUN
    } pls_state_t;

    typedef logic [TS_WIDTH:0] pls_cnt_t;

endpackage

// File: rtl/pls_gen.sv
// Pulse FIFO consumer: turns PlsData words into step/dir pulses
// with exact periods and reports the last issued step context.
module pls_gen
    import pls_gen_pkg::*;
#(
    parameter int PULSE_W   = PLS_W,
    parameter int DIR_SETUP = DIR_SETUP_DEF
) (
    input  logic      clk,
    input  logic      sclr_n,
    input  logic      enable,
    input  logic      fifo_empty,
    input  pls_data_t fifo_q,
    input  logic      fifo_sop,
    input  logic      fifo_eop,
    output logic      fifo_rdreq,
    output logic      step,
    output logic      dir,
    output pls_ctx_t  cur_data,
    output logic      busy,
    output logic      eop_done,
    output logic      underrun
);

    localparam pls_cnt_t MIN_T   = pls_cnt_t'(2 * PULSE_W);
    localparam pls_cnt_t PW      = pls_cnt_t'(PULSE_W);
    localparam pls_cnt_t DSET_LD = pls_cnt_t'(DIR_SETUP - 1);
    localparam pls_cnt_t ONE     = pls_cnt_t'(1);

    pls_state_t state;
    pls_cnt_t   cnt;
    pls_cnt_t   te_l;
    pls_cnt_t   q_te;
    pls_cnt_t   t_ext;
    pls_cnt_t   pos;
    pls_ctx_t   ctx_l;
    logic       mask_l;
    logic       eop_l;
    logic       first;
    logic       last;
    logic       fetch;

    // A stop word (mask=0, T=0) takes a single cycle; all others are
    // stretched so the pulse always has a full low half.
    always_comb begin
        t_ext = {1'b0, fifo_q.t};
        q_te  = t_ext;
        if (!fifo_q.mask && fifo_q.t == '0)
            q_te = ONE;
        else if (t_ext < MIN_T)
            q_te = MIN_T;
    end

    assign last       = (state == ST_RUN) && (cnt == '0);
    assign fetch      = enable && !fifo_empty &&
                        ((state == ST_IDLE) || last);
    assign fifo_rdreq = fetch && sclr_n;
    assign pos        = te_l - ONE - cnt;

    always_ff @(posedge clk) begin
        if (!sclr_n) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            te_l     <= '0;
            ctx_l    <= '0;
            mask_l   <= 1'b0;
            eop_l    <= 1'b0;
            first    <= 1'b0;
            step     <= 1'b0;
            dir      <= 1'b0;
            cur_data <= '0;
            busy     <= 1'b0;
            eop_done <= 1'b0;
            underrun <= 1'b0;
        end else begin
            eop_done <= 1'b0;
            step     <= (state == ST_RUN) && mask_l && (pos < PW);
            unique case (state)
                ST_IDLE: ;
                ST_DSET: begin
                    if (cnt == '0) begin
                        state <= ST_RUN;
                        cnt   <= te_l - ONE;
                    end else begin
                        cnt <= cnt - ONE;
                    end
                end
                ST_RUN: begin
                    if (first) begin
                        cur_data <= ctx_l;
                        first    <= 1'b0;
                    end
                    if (cnt != '0) begin
                        cnt <= cnt - ONE;
                    end else begin
                        if (eop_l) begin
                            eop_done <= 1'b1;
                            busy     <= 1'b0;
                        end else if (fifo_empty && busy) begin
                            underrun <= 1'b1;
                        end
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
            // A fetch in the last RUN cycle starts the next period on
            // this same edge, keeping back-to-back steps exactly Te apart.
            if (fetch) begin
                te_l   <= q_te;
                mask_l <= fifo_q.mask;
                eop_l  <= fifo_eop;
                first  <= 1'b1;
                ctx_l  <= '{id: fifo_q.id, n: fifo_q.n,
                            v: fifo_q.v, is_v: fifo_q.is_v};
                if (fifo_sop)
                    busy <= 1'b1;
                if (fifo_q.mask && (fifo_q.dir != dir)) begin
                    dir   <= fifo_q.dir;
                    cnt   <= DSET_LD;
                    state <= ST_DSET;
                end else begin
                    cnt   <= q_te - ONE;
                    state <= ST_RUN;
                end
            end
        end
    end

endmodule
